// File: rtl/offnariscv_pkg.sv
// ---------------------------------------------------------------------------
// offnariscv_pkg
//   Shared types and constants for the front-end program counter generator.
//   - XLEN                 : architectural address width
//   - PCG_EPOCH_W          : default width of the fetch epoch tag
//   - DEFAULT_RESET_VECTOR : first fetch PC after reset
//   - pcgif_tdata_t        : payload of the PCG -> instruction fetch stream
//   - pcg_state_e          : PC generator control states
//   - align_target()       : clears the low two bits of a redirect target
//   - next_seq_pc()        : sequential successor of a fetch PC
// ---------------------------------------------------------------------------
package offnariscv_pkg;

  localparam int XLEN        = 32;
  localparam int PCG_EPOCH_W = 2;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;
  localparam logic [XLEN-1:0] PC_STEP              = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [PCG_EPOCH_W-1:0] epoch;
  } pcgif_tdata_t;

  typedef enum logic [1:0] {
    PCG_BOOT  = 2'd0,
    PCG_RUN   = 2'd1,
    PCG_FLUSH = 2'd2
  } pcg_state_e;

  // Misaligned targets are reported elsewhere; here they are simply forced
  // onto a word boundary.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
    return {target[XLEN-1:2], 2'b00};
  endfunction

  // Wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/axis_if.sv
// ---------------------------------------------------------------------------
// axis_if
//   Minimal AXI-Stream channel (tvalid / tready / tdata).
//   - DATA_W : width of tdata
//   Modports:
//   - m : stream source (drives tvalid, tdata; samples tready)
//   - s : stream sink   (samples tvalid, tdata; drives tready)
// ---------------------------------------------------------------------------
interface axis_if #(
  parameter int DATA_W = 32
);

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);

endinterface

// File: rtl/pc_generator.sv
// ---------------------------------------------------------------------------
// pc_generator
//   Front-end program counter generator. Emits the sequential fetch-PC
//   stream toward instruction fetch and accepts redirect targets from the
//   committer. Every accepted redirect flushes the front end for one cycle
//   and bumps the fetch epoch so downstream stages can drop stale beats.
//
//   Parameters:
//   - RESET_VECTOR : first fetch PC after reset
//   - EPOCH_W      : width of the fetch epoch tag
//
//   Ports:
//   - clk           in   clock
//   - rst           in   asynchronous, active-high reset
//   - wbpcg_axis_if sink     redirect target from the committer (XLEN tdata)
//   - pcgif_axis_if source   fetch request {pc, epoch} to instruction fetch
//   - flush         out  front-end flush, high for the whole FLUSH state
//   - epoch         out  current fetch epoch
// ---------------------------------------------------------------------------
module pc_generator
  import offnariscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int              EPOCH_W      = PCG_EPOCH_W
) (
  input  logic               clk,
  input  logic               rst,
  axis_if.s                  wbpcg_axis_if,
  axis_if.m                  pcgif_axis_if,
  output logic               flush,
  output logic [EPOCH_W-1:0] epoch
);

  pcg_state_e         state_q;
  pcg_state_e         state_d;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    pc_d;
  logic [EPOCH_W-1:0] epoch_q;
  logic [EPOCH_W-1:0] epoch_d;

  logic fetch_valid;
  logic redirect_ready;
  logic flush_active;
  logic redirect_fire;
  logic fetch_fire;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PCG_BOOT;
      pc_q    <= RESET_VECTOR;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  // Handshakes. redirect_ready depends on state only, so there is no
  // combinational path from the committer's tvalid back to its tready.
  assign redirect_fire = wbpcg_axis_if.tvalid && redirect_ready;
  assign fetch_fire    = fetch_valid && pcgif_axis_if.tready;

  // -------------------------------------------------------------------------
  // Next-state / next-PC logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;

    unique case (state_q)
      PCG_BOOT: begin
        state_d = PCG_RUN;
      end

      PCG_RUN: begin
        // A redirect wins over a same-cycle output handshake: the beat that
        // transferred carries the old epoch and is dropped by the flush.
        if (redirect_fire) begin
          pc_d    = align_target(wbpcg_axis_if.tdata);
          epoch_d = epoch_q + EPOCH_W'(1);
          state_d = PCG_FLUSH;
        end else if (fetch_fire) begin
          pc_d = next_seq_pc(pc_q);
        end
      end

      PCG_FLUSH: begin
        // A redirect arriving during the flush restarts it for one more cycle.
        if (redirect_fire) begin
          pc_d    = align_target(wbpcg_axis_if.tdata);
          epoch_d = epoch_q + EPOCH_W'(1);
          state_d = PCG_FLUSH;
        end else begin
          state_d = PCG_RUN;
        end
      end

      default: begin
        state_d = PCG_BOOT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode (from registered state only)
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_valid    = 1'b0;
    redirect_ready = 1'b0;
    flush_active   = 1'b0;

    unique case (state_q)
      PCG_RUN: begin
        fetch_valid    = 1'b1;
        redirect_ready = 1'b1;
      end
      PCG_FLUSH: begin
        redirect_ready = 1'b1;
        flush_active   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pcgif_axis_if.tvalid = fetch_valid;
  assign pcgif_axis_if.tdata  = {pc_q, epoch_q};
  assign wbpcg_axis_if.tready = redirect_ready;
  assign flush                = flush_active;
  assign epoch                = epoch_q;

endmodule
